// File: rtl/ahb_lite_master_bridge.sv
// ahb_lite_master_bridge
// Turns a valid/ready load/store request port into single AHB-Lite transfers.
// The address phase of the next request overlaps the data phase of the current
// one. One response per request, returned in order.
// Optional build macro AHB_MASTER_RDATA_ALIGN_EN: right-align read data by the
// byte lane and size of the transfer instead of returning raw HRDATA lanes.
module ahb_lite_master_bridge #(
  parameter int         AHB_ADDR_WIDTH = 32,
  parameter int         AHB_DATA_WIDTH = 32,
  parameter logic [3:0] HPROT_VAL      = 4'b0011
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [AHB_ADDR_WIDTH-1:0] req_addr,
  input  logic                      req_write,
  input  logic [2:0]                req_size,
  input  logic [AHB_DATA_WIDTH-1:0] req_wdata,
  output logic                      rsp_valid,
  output logic [AHB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,
  output logic [AHB_ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]                HTRANS,
  output logic                      HWRITE,
  output logic [2:0]                HSIZE,
  output logic [2:0]                HBURST,
  output logic [3:0]                HPROT,
  output logic                      HMASTLOCK,
  output logic [AHB_DATA_WIDTH-1:0] HWDATA,
  input  logic [AHB_DATA_WIDTH-1:0] HRDATA,
  input  logic                      HREADY,
  input  logic                      HRESP
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  // address-phase slot
  logic                      a_valid;
  logic [AHB_ADDR_WIDTH-1:0] a_addr;
  logic                      a_write;
  logic [2:0]                a_size;
  logic [AHB_DATA_WIDTH-1:0] a_wdata;

  // data-phase slot
  logic                      d_valid;
  logic                      d_write;

  // set during the second cycle of an ERROR response: suppresses the pending
  // address phase so it is reissued once the bus is free
  logic                      cancel;

  logic                      accept;
  logic                      issue;
  logic [AHB_DATA_WIDTH-1:0] rdata_fmt;

  assign req_ready = !cancel && (!a_valid || HREADY);
  assign accept    = req_valid && req_ready;
  assign issue     = a_valid && !cancel;

  assign HTRANS    = issue ? TRANS_NONSEQ : TRANS_IDLE;
  assign HADDR     = a_addr;
  assign HWRITE    = a_write;
  assign HSIZE     = a_size;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

  // Address slot: load on accept, retire when the address phase completes
  // unless it was cancelled by an error (then it stays for reissue).
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      a_valid <= 1'b0;
      a_addr  <= '0;
      a_write <= 1'b0;
      a_size  <= '0;
      a_wdata <= '0;
    end else begin
      if (accept) begin
        a_valid <= 1'b1;
        a_addr  <= req_addr;
        a_write <= req_write;
        a_size  <= req_size;
        a_wdata <= req_wdata;
      end else if (HREADY && !cancel) begin
        a_valid <= 1'b0;
      end
    end
  end

  // Data slot, write data lanes and error-cancel flag advance only on HREADY.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      d_valid <= 1'b0;
      d_write <= 1'b0;
      HWDATA  <= '0;
      cancel  <= 1'b0;
    end else if (HREADY) begin
      d_valid <= issue;
      d_write <= a_write;
      if (issue && a_write) begin
        HWDATA <= a_wdata;
      end
      cancel  <= 1'b0;
    end else if (d_valid && HRESP) begin
      cancel  <= 1'b1;
    end
  end

`ifdef AHB_MASTER_RDATA_ALIGN_EN
  logic [1:0]                d_lane;
  logic [2:0]                d_size;
  logic [AHB_DATA_WIDTH-1:0] rd_shift;

  // Lane and size of the data-phase transfer, needed to align read data.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      d_lane <= '0;
      d_size <= '0;
    end else if (HREADY) begin
      d_lane <= a_addr[1:0];
      d_size <= a_size;
    end
  end

  assign rd_shift = HRDATA >> {d_lane, 3'b000};

  // Shift the addressed bytes down to bit 0 and zero-extend per size.
  always_comb begin
    rdata_fmt = '0;
    case (d_size)
      3'd0:    rdata_fmt[7:0]  = rd_shift[7:0];
      3'd1:    rdata_fmt[15:0] = rd_shift[15:0];
      default: rdata_fmt       = rd_shift;
    endcase
  end
`else
  assign rdata_fmt = HRDATA;
`endif

  // Response register: one pulse per completed data phase.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= d_valid && HREADY;
      rsp_err   <= HRESP;
      rsp_rdata <= (d_write || HRESP) ? '0 : rdata_fmt;
    end
  end

endmodule

// File: tb/tb_ahb_lite_master_bridge.sv
// Bench for ahb_lite_master_bridge: a directed cycle table covering write,
// back-to-back reads, wait states, ERROR and lane behaviour, a hand-written
// reset-mid-transfer sequence, then randomized traffic against a memory slave
// with an in-order reference model of request -> response.
module tb_ahb_lite_master_bridge;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
`ifdef AHB_MASTER_RDATA_ALIGN_EN
  localparam logic [31:0] EXP_BYTE3 = 32'h0000_00AB;
`else
  localparam logic [31:0] EXP_BYTE3 = 32'hAB00_0000;
`endif

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [2:0]  req_size = 3'd2;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;

  always #5 HCLK = ~HCLK;

  ahb_lite_master_bridge dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- directed cycle table ----------------
  typedef struct {
    logic        rv;     logic [31:0] addr;  logic wr;     logic [2:0] size;
    logic [31:0] wdata;  logic        hrdy;  logic hresp;  logic [31:0] hrdata;
    logic        e_ready; logic [1:0] e_trans; logic [31:0] e_haddr; logic e_hwrite;
    logic [31:0] e_hwdata; logic e_rv; logic e_err; logic [31:0] e_rdata;
  } vec_t;
  vec_t vq[$];

  task automatic add_row(input logic rv, input logic [31:0] addr, input logic wr,
                         input logic [2:0] size, input logic [31:0] wdata, input logic hrdy,
                         input logic hresp, input logic [31:0] hrdata, input logic e_ready,
                         input logic [1:0] e_trans, input logic [31:0] e_haddr,
                         input logic e_hwrite, input logic [31:0] e_hwdata, input logic e_rv,
                         input logic e_err, input logic [31:0] e_rdata);
    vec_t v;
    v.rv = rv; v.addr = addr; v.wr = wr; v.size = size; v.wdata = wdata;
    v.hrdy = hrdy; v.hresp = hresp; v.hrdata = hrdata;
    v.e_ready = e_ready; v.e_trans = e_trans; v.e_haddr = e_haddr; v.e_hwrite = e_hwrite;
    v.e_hwdata = e_hwdata; v.e_rv = e_rv; v.e_err = e_err; v.e_rdata = e_rdata;
    vq.push_back(v);
  endtask

  // ---------------- random slave + reference model ----------------
  typedef struct { logic [31:0] addr; logic write; logic [2:0] size; logic [31:0] wdata; } req_t;
  typedef struct { logic [31:0] rdata; logic err; } rsp_t;

  req_t        iq[$];
  rsp_t        eq[$];
  logic [31:0] sl_mem [16];
  logic [31:0] ref_mem[16];
  bit          sl_active;
  req_t        sl_req;
  int          sl_wait;
  bit          sl_errc;
  bit          have_prev;
  logic        p_hready, p_hresp;
  logic [1:0]  p_trans;
  logic [31:0] p_haddr;
  int          n_accepted;

  function automatic bit is_err(input logic [31:0] a);
    return a[7:6] == 2'b11;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] w, input logic [1:0] lane,
                                         input logic [2:0] size);
`ifdef AHB_MASTER_RDATA_ALIGN_EN
    logic [31:0] s;
    s = w >> (8 * lane);
    if (size == 3'd0) return s & 32'h0000_00FF;
    if (size == 3'd1) return s & 32'h0000_FFFF;
    return s;
`else
    return w;
`endif
  endfunction

  task automatic rnd_cycle(input bit allow_new);
    logic        s_ready;
    logic [1:0]  s_trans;
    logic [31:0] s_haddr;
    logic        s_hwrite;
    logic [2:0]  s_hsize;
    bit          accepted;
    req_t        r;
    rsp_t        e;
    accepted = 0;
    @(negedge HCLK);
    s_ready = req_ready; s_trans = HTRANS; s_haddr = HADDR;
    s_hwrite = HWRITE; s_hsize = HSIZE;
    if (rsp_valid) begin
      if (eq.size() == 0) chk("rnd_rsp_unexpected", 1, 0);
      else begin
        e = eq.pop_front();
        chk("rnd_rsp_err", rsp_err, e.err);
        chk("rnd_rsp_rdata", rsp_rdata, e.rdata);
      end
    end
    if (have_prev && !p_hready && p_hresp) begin
      chk("rnd_err2_idle", s_trans, IDLE);
      chk("rnd_err2_ready", s_ready, 0);
    end else begin
      if (have_prev && !p_hready && p_trans == NONSEQ) begin
        chk("rnd_wait_trans", s_trans, NONSEQ);
        chk("rnd_wait_haddr", s_haddr, p_haddr);
      end
      if (HREADY) chk("rnd_ready_hi", s_ready, 1);
    end
    if (sl_active && HREADY && !HRESP && sl_req.write) begin
      chk("rnd_hwdata", HWDATA, sl_req.wdata);
      sl_mem[sl_req.addr[5:2]] = HWDATA;
    end
    have_prev = 1; p_hready = HREADY; p_hresp = HRESP; p_trans = s_trans; p_haddr = s_haddr;

    @(posedge HCLK); #1;
    if (req_valid && s_ready) begin
      accepted = 1;
      n_accepted++;
      r.addr = req_addr; r.write = req_write; r.size = req_size; r.wdata = req_wdata;
      iq.push_back(r);
      e.err = is_err(req_addr);
      e.rdata = (req_write || e.err) ? 32'h0 : exp_rd(ref_mem[req_addr[5:2]], req_addr[1:0], req_size);
      if (req_write && !e.err) ref_mem[req_addr[5:2]] = req_wdata;
      eq.push_back(e);
    end
    if (p_hready) begin
      sl_active = 0;
      if (s_trans == NONSEQ) begin
        if (iq.size() == 0) chk("rnd_nonseq_unexpected", 1, 0);
        else begin
          sl_req = iq.pop_front();
          chk("rnd_haddr", s_haddr, sl_req.addr);
          chk("rnd_hwrite", s_hwrite, sl_req.write);
          chk("rnd_hsize", s_hsize, sl_req.size);
          sl_active = 1;
          sl_errc = 0;
          sl_wait = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        end
      end
    end
    if (!sl_active) begin
      HREADY = 1; HRESP = 0; HRDATA = $urandom;
    end else if (sl_wait > 0) begin
      HREADY = 0; HRESP = 0; HRDATA = $urandom; sl_wait--;
    end else if (is_err(sl_req.addr)) begin
      HRDATA = $urandom; HRESP = 1; HREADY = sl_errc; sl_errc = 1;
    end else begin
      HREADY = 1; HRESP = 0;
      HRDATA = sl_req.write ? $urandom : sl_mem[sl_req.addr[5:2]];
    end
    if (!(req_valid && !accepted)) begin
      req_valid = allow_new && ($urandom_range(0, 9) < 7);
      req_addr  = {24'h0, 8'($urandom_range(0, 255))};
      req_write = 1'($urandom_range(0, 1));
      req_size  = 3'($urandom_range(0, 2));
      req_wdata = $urandom;
    end
  endtask

  initial begin
    logic [31:0] DB;
    DB = 32'hDEAD_BEEF;
    //       rv addr     wr sz wdata  rdy rsp hrdata      | rdy trans  haddr     hw hwdata rv er rdata
    add_row(1, 32'h10,  1, 2, DB,    1, 0, 32'h0,        1, IDLE,   32'h0,   0, 32'h0, 0, 0, 32'h0);
    add_row(1, 32'h00,  0, 2, 32'h0, 1, 0, 32'h0,        1, NONSEQ, 32'h10,  1, 32'h0, 0, 0, 32'h0);
    add_row(1, 32'h04,  0, 2, 32'h0, 1, 0, 32'h0,        1, NONSEQ, 32'h00,  0, DB,    0, 0, 32'h0);
    add_row(1, 32'h08,  0, 2, 32'h0, 1, 0, 32'h11,       1, NONSEQ, 32'h04,  0, DB,    1, 0, 32'h0);
    add_row(1, 32'h20,  0, 2, 32'h0, 1, 0, 32'h22,       1, NONSEQ, 32'h08,  0, DB,    1, 0, 32'h11);
    add_row(1, 32'h24,  0, 2, 32'h0, 1, 0, 32'h33,       1, NONSEQ, 32'h20,  0, DB,    1, 0, 32'h22);
    add_row(1, 32'h28,  0, 2, 32'h0, 0, 0, 32'h99,       0, NONSEQ, 32'h24,  0, DB,    1, 0, 32'h33);
    add_row(1, 32'h28,  0, 2, 32'h0, 0, 0, 32'h99,       0, NONSEQ, 32'h24,  0, DB,    0, 0, 32'h0);
    add_row(1, 32'h28,  0, 2, 32'h0, 0, 0, 32'h99,       0, NONSEQ, 32'h24,  0, DB,    0, 0, 32'h0);
    add_row(1, 32'h28,  0, 2, 32'h0, 1, 0, 32'h55,       1, NONSEQ, 32'h24,  0, DB,    0, 0, 32'h0);
    add_row(0, 32'h0,   0, 2, 32'h0, 1, 0, 32'h66,       1, NONSEQ, 32'h28,  0, DB,    1, 0, 32'h55);
    add_row(1, 32'h100, 0, 2, 32'h0, 1, 0, 32'h77,       1, IDLE,   32'h28,  0, DB,    1, 0, 32'h66);
    add_row(1, 32'h104, 0, 2, 32'h0, 1, 0, 32'h0,        1, NONSEQ, 32'h100, 0, DB,    1, 0, 32'h77);
    add_row(0, 32'h0,   0, 2, 32'h0, 0, 1, 32'h0,        0, NONSEQ, 32'h104, 0, DB,    0, 0, 32'h0);
    add_row(0, 32'h0,   0, 2, 32'h0, 1, 1, 32'h0,        0, IDLE,   32'h104, 0, DB,    0, 0, 32'h0);
    add_row(0, 32'h0,   0, 2, 32'h0, 1, 0, 32'h0,        1, NONSEQ, 32'h104, 0, DB,    1, 1, 32'h0);
    add_row(0, 32'h0,   0, 2, 32'h0, 1, 0, 32'h88,       1, IDLE,   32'h104, 0, DB,    0, 0, 32'h0);
    add_row(1, 32'h3,   0, 0, 32'h0, 1, 0, 32'h0,        1, IDLE,   32'h104, 0, DB,    1, 0, 32'h88);
    add_row(0, 32'h0,   0, 2, 32'h0, 1, 0, 32'h0,        1, NONSEQ, 32'h3,   0, DB,    0, 0, 32'h0);
    add_row(0, 32'h0,   0, 2, 32'h0, 1, 0, 32'hAB000000, 1, IDLE,   32'h3,   0, DB,    0, 0, 32'h0);
    add_row(0, 32'h0,   0, 2, 32'h0, 1, 0, 32'h0,        1, IDLE,   32'h3,   0, DB,    1, 0, EXP_BYTE3);

    // reset state
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_htrans", HTRANS, IDLE);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hwrite", HWRITE, 0);
    chk("rst_hsize", HSIZE, 0);
    chk("rst_hwdata", HWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("const_hburst", HBURST, 3'b000);
    chk("const_hprot", HPROT, 4'b0011);
    chk("const_hmastlock", HMASTLOCK, 0);
    @(posedge HCLK); #1;
    HRESET = 0;

    foreach (vq[i]) begin
      req_valid = vq[i].rv; req_addr = vq[i].addr; req_write = vq[i].wr;
      req_size = vq[i].size; req_wdata = vq[i].wdata;
      HREADY = vq[i].hrdy; HRESP = vq[i].hresp; HRDATA = vq[i].hrdata;
      @(negedge HCLK);
      chk($sformatf("row%0d_req_ready", i), req_ready, vq[i].e_ready);
      chk($sformatf("row%0d_htrans", i), HTRANS, vq[i].e_trans);
      chk($sformatf("row%0d_haddr", i), HADDR, vq[i].e_haddr);
      chk($sformatf("row%0d_hwrite", i), HWRITE, vq[i].e_hwrite);
      chk($sformatf("row%0d_hwdata", i), HWDATA, vq[i].e_hwdata);
      chk($sformatf("row%0d_rsp_valid", i), rsp_valid, vq[i].e_rv);
      if (vq[i].e_rv) begin
        chk($sformatf("row%0d_rsp_err", i), rsp_err, vq[i].e_err);
        chk($sformatf("row%0d_rsp_rdata", i), rsp_rdata, vq[i].e_rdata);
      end
      @(posedge HCLK); #1;
    end

    // reset while a read is in its data phase
    req_valid = 1; req_addr = 32'h40; req_write = 0; req_size = 3'd2;
    HREADY = 1; HRESP = 0; HRDATA = 32'h0;
    @(negedge HCLK);
    chk("rstseq_ready", req_ready, 1);
    @(posedge HCLK); #1;
    req_valid = 0;
    @(negedge HCLK);
    chk("rstseq_nonseq", HTRANS, NONSEQ);
    chk("rstseq_haddr", HADDR, 32'h40);
    @(posedge HCLK); #1;
    HREADY = 0;
    @(negedge HCLK); #1;
    HRESET = 1;
    #1;
    chk("rstmid_htrans", HTRANS, IDLE);
    chk("rstmid_haddr", HADDR, 0);
    chk("rstmid_hwdata", HWDATA, 0);
    chk("rstmid_rsp_valid", rsp_valid, 0);
    chk("rstmid_rsp_rdata", rsp_rdata, 0);
    chk("rstmid_rsp_err", rsp_err, 0);
    HREADY = 1; HRDATA = 32'h1234;
    repeat (2) begin
      @(negedge HCLK);
      chk("rstmid_hold_rsp_valid", rsp_valid, 0);
    end
    @(posedge HCLK); #1;
    HRESET = 0;
    repeat (3) begin
      @(negedge HCLK);
      chk("rstpost_rsp_valid", rsp_valid, 0);
      chk("rstpost_htrans", HTRANS, IDLE);
    end
    @(posedge HCLK); #1;
    req_valid = 1; req_addr = 32'h44; req_write = 0;
    @(negedge HCLK);
    chk("rstpost_ready", req_ready, 1);
    @(posedge HCLK); #1;
    req_valid = 0;
    @(negedge HCLK);
    chk("rstpost_nonseq", HTRANS, NONSEQ);
    chk("rstpost_haddr", HADDR, 32'h44);
    @(posedge HCLK); #1;
    HRDATA = 32'h5A5A_5A5A;
    @(negedge HCLK);
    chk("rstpost_no_early_rsp", rsp_valid, 0);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("rstpost_rsp_valid", rsp_valid, 1);
    chk("rstpost_rsp_err", rsp_err, 0);
    chk("rstpost_rsp_rdata", rsp_rdata, 32'h5A5A_5A5A);

    // randomized traffic
    @(posedge HCLK); #1;
    HRESET = 1;
    req_valid = 0; HREADY = 1; HRESP = 0;
    sl_active = 0; have_prev = 0; n_accepted = 0;
    for (int i = 0; i < 16; i++) begin
      sl_mem[i] = $urandom;
      ref_mem[i] = sl_mem[i];
    end
    @(posedge HCLK); #1;
    HRESET = 0;
    for (int c = 0; c < 3000; c++) rnd_cycle(1);
    for (int k = 0; k < 300 && (eq.size() != 0 || req_valid); k++) rnd_cycle(0);
    chk("rnd_drain_rsp_queue", eq.size(), 0);
    chk("rnd_drain_issue_queue", iq.size(), 0);
    chk("rnd_traffic_seen", n_accepted > 500, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
